// File: rtl/jtag_tap_pkg.sv
// +------------------------------------------------------------------+
// | jtag_tap_pkg: TAP state encoding, fixed IR codes, DR code helper.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TestLogicReset = 4'd0,
    RunTestIdle    = 4'd1,
    SelectDrScan   = 4'd2,
    CaptureDr      = 4'd3,
    ShiftDr        = 4'd4,
    Exit1Dr        = 4'd5,
    PauseDr        = 4'd6,
    Exit2Dr        = 4'd7,
    UpdateDr       = 4'd8,
    SelectIrScan   = 4'd9,
    CaptureIr      = 4'd10,
    ShiftIr        = 4'd11,
    Exit1Ir        = 4'd12,
    PauseIr        = 4'd13,
    Exit2Ir        = 4'd14,
    UpdateIr       = 4'd15
  } tap_state_e;

  localparam int unsigned BYPASS0 = 0;
  localparam int unsigned IDCODE  = 1;

  function automatic int unsigned ir_code_for_dr(input int unsigned base, input int unsigned idx);
    return base + idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
// +------------------------------------------------------------------+
// | jtag_tap_fsm: IEEE 1149.1 16-state TAP controller with strobes.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       test_logic_reset_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TestLogicReset;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  always_comb begin
    state_o            = state_q;
    test_logic_reset_o = (state_q == TestLogicReset);
    capture_dr_o       = (state_q == CaptureDr);
    shift_dr_o         = (state_q == ShiftDr);
    update_dr_o        = (state_q == UpdateDr);
  end

endmodule

`default_nettype wire

// File: rtl/jtag_tap_multi_dr.sv
// +------------------------------------------------------------------+
// | jtag_tap_multi_dr: TAP with IR, BYPASS, IDCODE and NumDr user DRs|
// | Option macro JTAG_TAP_MULTI_DR_LOCK_EN adds lock_i. Rev 1.0      |
// +------------------------------------------------------------------+
`default_nettype none

module jtag_tap_multi_dr
  import jtag_tap_pkg::*;
#(
  parameter int unsigned          IrLength    = 5,
  parameter logic [31:0]          IdcodeValue = 32'h00000001,
  parameter int unsigned          NumDr       = 2,
  parameter int unsigned          DrWidth     = 32,
  parameter int unsigned          UserIrBase  = 'h10,
  parameter logic [IrLength-1:0]  IrCapture   = 'b00101
) (
  input  logic                     tck_i,
  input  logic                     trst_ni,
  input  logic                     tms_i,
  input  logic                     td_i,
  output logic                     td_o,
  output logic                     tdo_oe_o,
  input  logic                     testmode_i,
`ifdef JTAG_TAP_MULTI_DR_LOCK_EN
  input  logic                     lock_i,
`endif
  output logic                     test_logic_reset_o,
  output logic                     capture_dr_o,
  output logic                     shift_dr_o,
  output logic                     update_dr_o,
  output logic [NumDr-1:0]         dr_sel_o,
  input  logic [NumDr*DrWidth-1:0] cap_data_i,
  output logic [DrWidth-1:0]       upd_data_o,
  output logic [NumDr-1:0]         upd_valid_o
);

  tap_state_e state;
  logic       tlr, capture_dr, shift_dr, update_dr;
  logic       capture_ir, shift_ir, update_ir;

  jtag_tap_fsm u_fsm (
    .tck_i              (tck_i),
    .trst_ni            (trst_ni),
    .tms_i              (tms_i),
    .state_o            (state),
    .test_logic_reset_o (tlr),
    .capture_dr_o       (capture_dr),
    .shift_dr_o         (shift_dr),
    .update_dr_o        (update_dr)
  );

  assign capture_ir = (state == CaptureIr);
  assign shift_ir   = (state == ShiftIr);
  assign update_ir  = (state == UpdateIr);

  logic [IrLength-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [31:0]         idcode_q, idcode_d;
  logic                bypass_q, bypass_d;
  logic [DrWidth-1:0]  user_sr_q, user_sr_d, upd_data_q, upd_data_d;
  logic [NumDr-1:0]    upd_valid_q, upd_valid_d, dr_sel;
  logic [DrWidth-1:0]  cap_sel;
  logic                sel_idcode, sel_user, locked;
  logic                tdo_d, td_q, tdo_oe_q;

`ifdef JTAG_TAP_MULTI_DR_LOCK_EN
  // Lock is latched alongside the IR so a DR scan in flight keeps its selection.
  logic lock_q, lock_d;
  assign lock_d = update_ir ? lock_i : lock_q;
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) lock_q <= 1'b0;
    else          lock_q <= lock_d;
  end
  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  for (genvar i = 0; i < NumDr; i++) begin : g_dr_sel
    localparam logic [IrLength-1:0] IR_CODE = IrLength'(ir_code_for_dr(UserIrBase, i));
    assign dr_sel[i] = (ir_q == IR_CODE) && !locked;
  end

  assign sel_idcode = (ir_q == IrLength'(IDCODE));
  assign sel_user   = |dr_sel;

  always_comb begin
    cap_sel = '0;
    for (int i = 0; i < NumDr; i++) begin
      if (dr_sel[i]) cap_sel = cap_sel | cap_data_i[i*DrWidth +: DrWidth];
    end
  end

  always_comb begin
    ir_d        = ir_q;
    ir_sr_d     = ir_sr_q;
    idcode_d    = idcode_q;
    bypass_d    = bypass_q;
    user_sr_d   = user_sr_q;
    upd_data_d  = upd_data_q;
    upd_valid_d = '0;

    if (capture_ir)    ir_sr_d = IrCapture;
    else if (shift_ir) ir_sr_d = {td_i, ir_sr_q[IrLength-1:1]};
    if (update_ir)     ir_d    = ir_sr_q;

    // Codes that are neither IDCODE nor an unlocked user DR fall through to BYPASS.
    if (capture_dr) begin
      if (sel_idcode)    idcode_d  = IdcodeValue;
      else if (sel_user) user_sr_d = cap_sel;
      else               bypass_d  = 1'b0;
    end else if (shift_dr) begin
      if (sel_idcode)    idcode_d  = {td_i, idcode_q[31:1]};
      else if (sel_user) user_sr_d = {td_i, user_sr_q[DrWidth-1:1]};
      else               bypass_d  = td_i;
    end

    if (update_dr && sel_user) begin
      upd_data_d  = user_sr_q;
      upd_valid_d = dr_sel;
    end

    if (tlr) begin
      ir_d     = IrLength'(IDCODE);
      ir_sr_d  = '0;
      idcode_d = IdcodeValue;
      bypass_d = 1'b0;
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_q        <= IrLength'(IDCODE);
      ir_sr_q     <= '0;
      idcode_q    <= IdcodeValue;
      bypass_q    <= 1'b0;
      user_sr_q   <= '0;
      upd_data_q  <= '0;
      upd_valid_q <= '0;
    end else begin
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      idcode_q    <= idcode_d;
      bypass_q    <= bypass_d;
      user_sr_q   <= user_sr_d;
      upd_data_q  <= upd_data_d;
      upd_valid_q <= upd_valid_d;
    end
  end

  always_comb begin
    if (shift_ir)        tdo_d = ir_sr_q[0];
    else if (sel_idcode) tdo_d = idcode_q[0];
    else if (sel_user)   tdo_d = user_sr_q[0];
    else                 tdo_d = bypass_q;
  end

  // Clock inverter with scan bypass: TDO launches on falling tck outside test mode.
  logic tck_n;
  assign tck_n = testmode_i ? tck_i : ~tck_i;

  always_ff @(posedge tck_n or negedge trst_ni) begin
    if (!trst_ni) begin
      td_q     <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      td_q     <= tdo_d;
      tdo_oe_q <= shift_ir | shift_dr;
    end
  end

  assign td_o               = td_q;
  assign tdo_oe_o           = tdo_oe_q;
  assign test_logic_reset_o = tlr;
  assign capture_dr_o       = capture_dr;
  assign shift_dr_o         = shift_dr;
  assign update_dr_o        = update_dr;
  assign dr_sel_o           = dr_sel;
  assign upd_data_o         = upd_data_q;
  assign upd_valid_o        = upd_valid_q;

endmodule

`default_nettype wire
